// File: rtl/sys_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// sys_bus_ctrl_if
// Bus bundle for sys_bus_ctrl: the CPU-side master request/response signals
// and the decoded slave-side address/data/select signals.
//
// Handshake semantics (single place these are written down):
//   * m_req is sampled only while the controller is idle (m_busy = 0).
//     The master values m_we/m_addr/m_wdata are captured on that edge and
//     may change freely afterwards.
//   * m_ack is a one-cycle completion pulse; m_err and m_rdata are valid
//     with it, and m_rdata holds until the next completion.
//   * A slave sees s_sel[k] = 1 with s_addr/s_wdata/s_we stable and answers
//     by raising s_ready[k]; only the selected bit of s_ready is looked at,
//     and only during the data phase.
//
// Modports:
//   ctrl   - the bus controller itself
//   master - the CPU-side requester
//   slave  - the slave-port side (register files, memory banks)
// ---------------------------------------------------------------------------
interface sys_bus_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic                             m_req;
    logic                             m_we;
    logic [ADDR_WIDTH-1:0]            m_addr;
    logic [DATA_WIDTH-1:0]            m_wdata;
    logic                             m_ack;
    logic                             m_err;
    logic [DATA_WIDTH-1:0]            m_rdata;
    logic                             m_busy;

    logic [NUM_SLAVES-1:0]            s_sel;
    logic                             s_we;
    logic [ADDR_WIDTH-1:0]            s_addr;
    logic [DATA_WIDTH-1:0]            s_wdata;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]            s_ready;

    modport ctrl (
        input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
        output m_ack, m_err, m_rdata, m_busy, s_sel, s_we, s_addr, s_wdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_ack, m_err, m_rdata, m_busy
    );

    modport slave (
        input  s_sel, s_we, s_addr, s_wdata,
        output s_rdata, s_ready
    );
endinterface

// File: rtl/sys_bus_ctrl.sv
// ---------------------------------------------------------------------------
// sys_bus_ctrl
// Single-master system bus controller. Accepts one read or write at a time
// from the CPU side, decodes the top SEL_WIDTH address bits to one of
// NUM_SLAVES slave ports, runs an address phase and a data phase with a
// per-slave ready handshake, and returns data plus an error flag.
//
// Ports:
//   clk     - clock, all logic on posedge
//   rst     - synchronous, active-high reset
//   bus     - sys_bus_ctrl_if.ctrl (master request/response + slave side)
//   o_state - one-hot FSM state for observation {COMP, DATA, ADDR, IDLE}
//
// Optional feature macro: SYS_BUS_TIMEOUT_EN
//   When defined, the data phase is bounded to TIMEOUT_CYCLES cycles and a
//   slave that never answers completes with m_err = 1. When undefined the
//   data phase waits indefinitely and m_err reports decode errors only.
// ---------------------------------------------------------------------------
module sys_bus_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = 2,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    sys_bus_ctrl_if.ctrl  bus,
    output logic [3:0]    o_state
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ADDR = 4'b0010,
        ST_DATA = 4'b0100,
        ST_COMP = 4'b1000
    } state_t;

    state_t                r_state;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NUM_SLAVES-1:0] r_sel;
    logic                  r_dec_err;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

`ifdef SYS_BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]      r_cnt;
`else
    // Keeps the timeout parameter referenced when the feature is compiled out.
    logic                  w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 1);
`endif

    logic [SEL_WIDTH-1:0]  w_idx;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Slave index from the incoming address. An index at or above NUM_SLAVES
    // matches no bit, so an all-zero one-hot is the decode-error condition.
    always_comb begin
        w_idx    = bus.m_addr[ADDR_WIDTH-1 -: SEL_WIDTH];
        w_onehot = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_onehot[k] = (w_idx == SEL_WIDTH'(k));
        end
    end

    // The latched one-hot select masks both ready and read data, so
    // unselected slaves can never complete or corrupt a transaction.
    always_comb begin
        w_ready = |(bus.s_ready & r_sel);
        w_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (r_sel[k]) begin
                w_rdata = w_rdata | bus.s_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_dec_err <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
`ifdef SYS_BUS_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.m_req) begin
                        // Slave-side outputs are loaded here so they are
                        // already stable during the address-phase cycle.
                        r_we      <= bus.m_we;
                        r_addr    <= bus.m_addr;
                        r_wdata   <= bus.m_wdata;
                        r_sel     <= w_onehot;
                        r_dec_err <= (w_onehot == '0);
                        r_state   <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (r_dec_err) begin
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_we    <= 1'b0;
                        r_sel   <= '0;
                        r_state <= ST_COMP;
                    end else begin
`ifdef SYS_BUS_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_ready) begin
                        // Ready on the final allowed cycle still completes
                        // normally: this branch is checked before the timeout.
                        r_ack   <= 1'b1;
                        r_err   <= 1'b0;
                        r_rdata <= r_we ? '0 : w_rdata;
                        r_we    <= 1'b0;
                        r_sel   <= '0;
                        r_state <= ST_COMP;
                    end
`ifdef SYS_BUS_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_we    <= 1'b0;
                        r_sel   <= '0;
                        r_state <= ST_COMP;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
`endif
                end

                ST_COMP: begin
                    // m_req is not looked at here; it is next sampled in IDLE.
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_we    <= 1'b0;
                    r_sel   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m_ack   = r_ack;
    assign bus.m_err   = r_err;
    assign bus.m_rdata = r_rdata;
    assign bus.m_busy  = (r_state != ST_IDLE);
    assign bus.s_sel   = r_sel;
    assign bus.s_we    = r_we;
    assign bus.s_addr  = r_addr;
    assign bus.s_wdata = r_wdata;
    assign o_state     = r_state;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sys_bus_ctrl
// Directed bench for sys_bus_ctrl. One instance with four slaves carries
// most traffic; a second with three slaves exercises the decode error.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sys_bus_ctrl;

    logic clk;
    logic rst;
    logic [3:0] dbg_state;
    logic [3:0] dbg_state3;

    int n_cmp;
    int n_bad;

    logic [31:0] slot [4];
    logic [31:0] exp_q [$];

    sys_bus_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_SLAVES(4)) b ();
    sys_bus_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_SLAVES(3)) b3 ();

    sys_bus_ctrl #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .SEL_WIDTH(2),
        .NUM_SLAVES(4), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(b.ctrl), .o_state(dbg_state)
    );

    sys_bus_ctrl #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .SEL_WIDTH(2),
        .NUM_SLAVES(3), .TIMEOUT_CYCLES(16)
    ) u_dut3 (
        .clk(clk), .rst(rst), .bus(b3.ctrl), .o_state(dbg_state3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] addr_at(input int c);
        logic [7:0] r;
        r = 8'h10 + 8'(c * 41);
        return r;
    endfunction

    // ---------------- driver ----------------
    // Called on a falling edge of an IDLE cycle (cycle 0). The slave stays
    // not-ready (only unselected slaves ready) until DATA cycle 'delay'+1,
    // i.e. tb cycle 2+delay. Returns on a falling edge of the IDLE cycle
    // that follows completion.
    task automatic do_txn(input string name, input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input int delay,
                          input logic [3:0] exp_sel, input int exp_sel_cyc,
                          input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rdata);
        int lat;
        int sel_cyc;
        lat     = -1;
        sel_cyc = 0;
        b.m_req   = 1'b1;
        b.m_we    = we;
        b.m_addr  = addr;
        b.m_wdata = wdata;
        b.s_ready = ~exp_sel;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            b.m_req   = 1'b0;
            b.m_addr  = ~addr;
            b.m_wdata = ~wdata;
            b.m_we    = ~we;
            if (c == 1) check_eq({name, "_sel"}, b.s_sel, exp_sel);
            if (b.s_sel == exp_sel && b.s_we == we && b.s_addr == addr && b.s_wdata == wdata)
                sel_cyc++;
            if (b.m_ack) begin
                lat = c;
                break;
            end
            b.s_ready = (c >= 2 + delay) ? 4'b1111 : ~exp_sel;
        end
        check_eq({name, "_lat"}, lat, exp_lat);
        check_eq({name, "_selcyc"}, sel_cyc, exp_sel_cyc);
        check_eq({name, "_err"}, b.m_err, exp_err);
        check_eq({name, "_rdata"}, b.m_rdata, exp_rdata);
        check_eq({name, "_compsel"}, b.s_sel, 4'b0000);
        b.s_ready = 4'b0000;
        @(negedge clk);
        check_eq({name, "_ackdrop"}, b.m_ack, 1'b0);
        check_eq({name, "_idle"}, b.m_busy, 1'b0);
        check_eq({name, "_hold"}, b.m_rdata, exp_rdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] a;
        logic [31:0] e;
        n_cmp = 0;
        n_bad = 0;
        slot[0] = 32'h0000_AAAA;
        slot[1] = 32'hDEAD_BEEF;
        slot[2] = 32'h2222_BBBB;
        slot[3] = 32'h3333_CCCC;

        rst = 1'b1;
        b.m_req = 1'b0;  b.m_we = 1'b0;  b.m_addr = '0;  b.m_wdata = '0;
        b.s_ready = '0;  b.s_rdata = {slot[3], slot[2], slot[1], slot[0]};
        b3.m_req = 1'b0; b3.m_we = 1'b0; b3.m_addr = '0; b3.m_wdata = '0;
        b3.s_ready = '0; b3.s_rdata = {slot[2], slot[1], slot[0]};

        repeat (2) @(negedge clk);
        check_eq("rst_ack", b.m_ack, 1'b0);
        check_eq("rst_err", b.m_err, 1'b0);
        check_eq("rst_busy", b.m_busy, 1'b0);
        check_eq("rst_rdata", b.m_rdata, 32'h0);
        check_eq("rst_sel", b.s_sel, 4'b0000);
        check_eq("rst_we", b.s_we, 1'b0);
        check_eq("rst_addr", b.s_addr, 8'h00);
        check_eq("rst_wdata", b.s_wdata, 32'h0);
        check_eq("rst_state", dbg_state, 4'b0001);
        rst = 1'b0;
        @(negedge clk);

        // Read slave 1, ready immediately: ack in cycle 3.
        do_txn("rd45", 1'b0, 8'h45, 32'h0, 0, 4'b0010, 2, 3, 1'b0, 32'hDEAD_BEEF);
        // Write slave 3, ready after 3 wait cycles: 4 DATA cycles, ack in 6.
        do_txn("wrC3", 1'b1, 8'hC3, 32'h1234_5678, 3, 4'b1000, 5, 6, 1'b0, 32'h0);
        // Read slave 0 while other slaves report ready during the wait.
        do_txn("rd05", 1'b0, 8'h05, 32'h0, 1, 4'b0001, 3, 4, 1'b0, 32'h0000_AAAA);
        // Ready in the 16th DATA cycle completes normally in either build.
        do_txn("rd40w", 1'b0, 8'h40, 32'h0, 15, 4'b0010, 17, 18, 1'b0, 32'hDEAD_BEEF);
`ifdef SYS_BUS_TIMEOUT_EN
        // Slave never ready: 16 DATA cycles then error completion.
        do_txn("rd40to", 1'b0, 8'h40, 32'h0, 1000, 4'b0010, 17, 18, 1'b1, 32'h0);
`endif

        // Decode error on the three-slave instance: ack with error in cycle 2.
        b3.m_req = 1'b1; b3.m_we = 1'b1; b3.m_addr = 8'hC0; b3.m_wdata = 32'h5555_5555;
        b3.s_ready = 3'b111;
        @(negedge clk);
        b3.m_req = 1'b0;
        check_eq("dec_sel1", b3.s_sel, 3'b000);
        check_eq("dec_ack1", b3.m_ack, 1'b0);
        check_eq("dec_busy1", b3.m_busy, 1'b1);
        @(negedge clk);
        check_eq("dec_ack2", b3.m_ack, 1'b1);
        check_eq("dec_err2", b3.m_err, 1'b1);
        check_eq("dec_rdata2", b3.m_rdata, 32'h0);
        check_eq("dec_sel2", b3.s_sel, 3'b000);
        @(negedge clk);
        check_eq("dec_ack3", b3.m_ack, 1'b0);
        check_eq("dec_busy3", b3.m_busy, 1'b0);
        // Valid slave 2 on the same instance.
        b3.m_req = 1'b1; b3.m_we = 1'b0; b3.m_addr = 8'h90;
        @(negedge clk);
        b3.m_req = 1'b0;
        check_eq("ok3_sel", b3.s_sel, 3'b100);
        @(negedge clk);
        check_eq("ok3_ack2", b3.m_ack, 1'b0);
        @(negedge clk);
        check_eq("ok3_ack3", b3.m_ack, 1'b1);
        check_eq("ok3_err", b3.m_err, 1'b0);
        check_eq("ok3_rdata", b3.m_rdata, 32'h2222_BBBB);
        b3.s_ready = 3'b000;

        // m_req held high: accepted at cycles 0, 4, 8; address changes every
        // cycle and must not leak into the transaction in flight.
        b.m_req = 1'b1; b.m_we = 1'b0; b.s_ready = 4'b1111;
        b.m_addr = addr_at(0);
        a = addr_at(0);
        exp_q.push_back(slot[a[7:6]]);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check_eq($sformatf("cont_ack_%0d", c), b.m_ack, (c % 4) == 3);
            check_eq($sformatf("cont_addr_%0d", c), b.s_addr, addr_at(4 * ((c - 1) / 4)));
            if (b.m_ack) begin
                if (exp_q.size() == 0) begin
                    check_eq($sformatf("cont_extra_%0d", c), 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("cont_rdata_%0d", c), b.m_rdata, e);
                end
            end
            b.m_addr = addr_at(c);
            if (c % 4 == 0 && c < 12) begin
                a = addr_at(c);
                exp_q.push_back(slot[a[7:6]]);
            end
            if (c == 12) b.m_req = 1'b0;
        end
        @(negedge clk);
        check_eq("cont_idle", b.m_busy, 1'b0);
        check_eq("cont_q", exp_q.size(), 0);
        b.s_ready = 4'b0000;

        // Reset while in DATA: transaction dropped, everything back to zero.
        b.m_req = 1'b1; b.m_we = 1'b1; b.m_addr = 8'h80; b.m_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        b.m_req = 1'b0;
        @(negedge clk);
        check_eq("rstd_state", dbg_state, 4'b0100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstd_idle", dbg_state, 4'b0001);
        check_eq("rstd_busy", b.m_busy, 1'b0);
        check_eq("rstd_ack", b.m_ack, 1'b0);
        check_eq("rstd_rdata", b.m_rdata, 32'h0);
        check_eq("rstd_sel", b.s_sel, 4'b0000);
        check_eq("rstd_we", b.s_we, 1'b0);
        check_eq("rstd_addr", b.s_addr, 8'h00);
        check_eq("rstd_wdata", b.s_wdata, 32'h0);
        b.s_ready = 4'b0100;
        @(negedge clk);
        check_eq("rstd_noack", b.m_ack, 1'b0);
        check_eq("rstd_stay", b.m_busy, 1'b0);
        do_txn("rd80", 1'b0, 8'h80, 32'h0, 1, 4'b0100, 3, 4, 1'b0, 32'h2222_BBBB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sys_bus_ctrl.md
# sys_bus_ctrl

Parametrised single-master system bus controller: the next-generation replacement for the fixed one-bit system bus. It accepts one read or write transaction at a time from the CPU-side master and decodes the address to one of `NUM_SLAVES` slave ports (register files, memory banks). It then runs an address phase and a data phase with a per-slave ready handshake, and returns data plus an error flag to the master. It sits between the core's load/store path and the `REG_32`/`MEM_32` style slaves.

## Interface
- `ADDR_WIDTH`, 8: address width; must be > `SEL_WIDTH`.
- `DATA_WIDTH`, 32: data width.
- `SEL_WIDTH`, 2: slave index = `addr[ADDR_WIDTH-1 -: SEL_WIDTH]`.
- `NUM_SLAVES`, 4: number of slave ports, 1..2**`SEL_WIDTH`.
- `TIMEOUT_CYCLES`, 16: maximum data-phase length, >= 2 (used only with the timeout feature).

Ports:
- `clk` in 1: clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `m_req` in 1: master request; sampled only in IDLE.
- `m_we` in 1: 1 = write, 0 = read.
- `m_addr` in `ADDR_WIDTH`: transaction address.
- `m_wdata` in `DATA_WIDTH`: write data.
- `m_ack` out 1: one-cycle completion pulse.
- `m_err` out 1: error qualifier, valid with `m_ack`.
- `m_rdata` out `DATA_WIDTH`: read data, valid from `m_ack`, held until the next completion.
- `m_busy` out 1: high in every state except IDLE.
- `s_sel` out `NUM_SLAVES`: one-hot slave select.
- `s_we` out 1: write strobe qualifier.
- `s_addr` out `ADDR_WIDTH`: full latched address.
- `s_wdata` out `DATA_WIDTH`: latched write data.
- `s_rdata` in `NUM_SLAVES*DATA_WIDTH`: slave k's data at bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `s_ready` in `NUM_SLAVES`: per-slave ready; only the selected bit is observed.

## Operation
- One-hot FSM with states IDLE, ADDR, DATA, COMP. Reset state is IDLE.
- IDLE: when `m_req`=1, latch `m_we`, `m_addr`, `m_wdata` and the slave index, then go to ADDR. Otherwise stay in IDLE.
- ADDR (1 cycle): drive `s_addr`, `s_wdata`, `s_we` and `s_sel` = one-hot(index).
  - If index >= `NUM_SLAVES`: decode error, `s_sel` stays 0, go to COMP with error.
  - Otherwise go to DATA.
- DATA: hold all slave outputs and wait for `s_ready[index]`.
  - When it is seen: on a read, capture the selected `s_rdata` slice; go to COMP with no error.
- COMP (1 cycle): `m_ack`=1 and `m_err` = the latched error.
  - `m_rdata` = captured data for a successful read; 0 for a write or any error.
  - `s_sel`=0, `s_we`=0. Go to IDLE.
  - `m_req` is ignored in COMP; it is accepted again in the following IDLE cycle.
- Changes to the master inputs after acceptance have no effect on the transaction in flight.
- `s_ready` for unselected slaves, and `s_ready` outside DATA, are ignored.
- Reset mid-transaction: the next state is IDLE and the transaction is dropped with no `m_ack`.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Reset values:
  - `m_ack`=0, `m_err`=0, `m_busy`=0.
  - `m_rdata`=0, `s_sel`=0, `s_we`=0.
  - `s_addr`=0, `s_wdata`=0.
- Minimum latency: `m_req` sampled at edge N, so ADDR in cycle N+1, DATA in cycle N+2 with ready, and `m_ack` high in cycle N+3.
- Each wait-state cycle in DATA adds one cycle of latency.
- Decode error: `m_ack` with `m_err`=1 in cycle N+2.
- Back-to-back transactions: the next request is accepted at the edge ending the IDLE cycle after COMP. Minimum spacing is 4 cycles per transaction.

## Configuration
- `SYS_BUS_TIMEOUT_EN` defined:
  - A data-phase counter clears on entering DATA and increments each DATA cycle.
  - If `s_ready[index]` is still low in the `TIMEOUT_CYCLES`-th DATA cycle, go to COMP with `m_err`=1 and `m_rdata`=0.
  - Ready in that same last cycle wins: the transaction completes normally.
- `SYS_BUS_TIMEOUT_EN` undefined: the counter is absent, DATA waits indefinitely, and `m_err` comes only from decode errors.

## Test plan
- Reset, then read slave 1, addr 8'h45, with `s_ready[1]`=1 and slave data 32'hDEADBEEF: `s_sel`=4'b0010 in the N+1 cycle, `m_ack`=1 in N+3, `m_rdata`=32'hDEADBEEF, `m_err`=0.
- Write addr 8'hC3, data 32'h12345678, with `s_ready[3]` delayed 3 cycles: `s_we`=1, `s_wdata`=32'h12345678 held 4 DATA cycles, `m_ack` in N+6, `m_rdata`=0.
- `NUM_SLAVES`=3, access addr 8'hC0: `s_sel` never asserted, `m_ack`=1 with `m_err`=1 in N+2.
- With the timeout enabled, `TIMEOUT_CYCLES`=16, `s_ready` tied 0: exactly 16 DATA cycles, then `m_ack`=1 with `m_err`=1 and `m_rdata`=0. Repeat with ready in the 16th cycle and expect `m_err`=0.
- `m_req` held high continuously: transactions complete every 4 cycles, and `m_addr` changes mid-transaction do not alter `s_addr`.
- Assert `rst` during DATA: IDLE next cycle, all outputs 0, no `m_ack`. A new request then completes normally.
